// File: rtl/stack_arbiter_if.sv
// Requester-side handshake bundle for stack_arbiter: one instance per requester.
interface stack_arbiter_if #(
  parameter int DATA_BITS = 8
);
  logic                 req;
  logic                 op;     // 1 = push, 0 = pop
  logic [DATA_BITS-1:0] wdata;
  logic                 ack;
  logic                 err;
  logic [DATA_BITS-1:0] rdata;

  modport master (output req, op, wdata, input ack, err, rdata);
  modport slave  (input req, op, wdata, output ack, err, rdata);
endinterface

// File: rtl/stack_arbiter.sv
// Two-requester arbiter in front of a shared LIFO; one stack op per req/ack transaction.
// Define STACK_ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module stack_arbiter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  stack_arbiter_if.slave       a,
  stack_arbiter_if.slave       b,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [DATA_BITS-1:0] stk_wdata,
  input  logic                 stk_empty,
  input  logic                 stk_full,
  input  logic [DATA_BITS-1:0] stk_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t               state, state_next;
  logic                 win_b;
  logic                 op_q;
  logic [DATA_BITS-1:0] wdata_q;
  logic                 err_q, err_next;
  logic [DATA_BITS-1:0] a_rdata_q, b_rdata_q;
  logic [DATA_BITS-1:0] pop_data;
  logic                 any_req;
  logic                 grant_b;

  assign any_req = a.req | b.req;

`ifdef STACK_ARB_FIXED_PRIO_EN
  assign grant_b = b.req & ~a.req;
`else
  logic last_b;

  // Starts as B so that A wins the first tie after reset.
  assign grant_b = b.req & (~a.req | ~last_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_b <= 1'b1;
    else if (state == ISSUE)
      last_b <= win_b;
  end
`endif

  // NOTE: every output-producing path defaults first, so no branch can infer a latch.
  always_comb begin
    state_next = state;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_wdata  = '0;
    err_next   = err_q;
    pop_data   = stk_empty ? '0 : stk_rdata;
    unique case (state)
      IDLE: begin
        if (any_req)
          state_next = ISSUE;
      end
      ISSUE: begin
        state_next = RESP;
        if (op_q) begin
          stk_push  = ~stk_full;
          stk_wdata = stk_full ? '0 : wdata_q;
          err_next  = stk_full;
        end else begin
          stk_pop  = ~stk_empty;
          err_next = stk_empty;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // the async reset clears all of it, which also drops the combinational strobes at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      win_b     <= 1'b0;
      op_q      <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state  <= state_next;
      err_q  <= err_next;
      if (state == IDLE && any_req) begin
        win_b   <= grant_b;
        op_q    <= grant_b ? b.op    : a.op;
        wdata_q <= grant_b ? b.wdata : a.wdata;
      end
      // The pre-pop top of stack is captured in the same cycle as the pop strobe.
      if (state == ISSUE && !op_q) begin
        if (win_b)
          b_rdata_q <= pop_data;
        else
          a_rdata_q <= pop_data;
      end
    end
  end

  assign a.ack   = (state == RESP) & ~win_b;
  assign b.ack   = (state == RESP) &  win_b;
  assign a.err   = a.ack & err_q;
  assign b.err   = b.ack & err_q;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a 16-deep stack model and a transaction-level reference.
`timescale 1ns/1ps
module tb_stack_arbiter;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  stack_arbiter_if #(.DATA_BITS(DW)) a_if ();
  stack_arbiter_if #(.DATA_BITS(DW)) b_if ();

  logic          stk_push, stk_pop, stk_empty, stk_full;
  logic [DW-1:0] stk_wdata, stk_rdata;

  stack_arbiter #(.DATA_BITS(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a_if),
    .b         (b_if),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_wdata (stk_wdata),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_rdata (stk_rdata)
  );

  always #5 clk = ~clk;

  // Shared Stack instance (environment), reset on the same net as the arbiter.
  logic [DW-1:0] mem [DEPTH];
  int            sp;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) sp <= 0;
    else if (stk_push && sp < DEPTH) begin
      mem[sp] <= stk_wdata;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == DEPTH);
  assign stk_rdata = (sp > 0) ? mem[sp-1] : '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a transaction is accepted when the arbiter is free, its strobe is
  // expected in the next cycle, its ack in the one after, then one idle cycle.
  logic [DW-1:0] mq[$];
  int            busy   = 0;
  bit            last_b = 1'b1;
  bit            p_b, p_op, p_err;
  logic [DW-1:0] p_rd;
  bit            e_push = 0, e_pop = 0, e_aack = 0, e_back = 0, e_aerr = 0, e_berr = 0;
  logic [DW-1:0] e_wd = '0, e_ard = '0, e_brd = '0;

  initial begin
    bit            win_b, op, ok;
    logic [DW-1:0] wd;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        busy = 0; last_b = 1'b1;
        e_push = 0; e_pop = 0; e_wd = '0;
        e_aack = 0; e_back = 0; e_aerr = 0; e_berr = 0;
        e_ard = '0; e_brd = '0;
      end else if (busy == 0) begin
        e_aack = 0; e_back = 0; e_aerr = 0; e_berr = 0;
        if (a_if.req || b_if.req) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
          win_b = b_if.req && !a_if.req;
`else
          win_b  = b_if.req && (!a_if.req || !last_b);
          last_b = win_b;
`endif
          op = win_b ? b_if.op : a_if.op;
          wd = win_b ? b_if.wdata : a_if.wdata;
          if (op) begin
            ok = (mq.size() < DEPTH);
            if (ok) mq.push_back(wd);
          end else begin
            ok   = (mq.size() > 0);
            p_rd = ok ? mq.pop_back() : '0;
          end
          e_push = op && ok;
          e_pop  = !op && ok;
          e_wd   = e_push ? wd : '0;
          p_b = win_b; p_op = op; p_err = !ok;
          busy = 2;
        end
      end else if (busy == 2) begin
        e_push = 0; e_pop = 0; e_wd = '0;
        if (p_b) begin
          e_back = 1; e_berr = p_err;
          if (!p_op) e_brd = p_rd;
        end else begin
          e_aack = 1; e_aerr = p_err;
          if (!p_op) e_ard = p_rd;
        end
        busy = 1;
      end else begin
        e_aack = 0; e_back = 0; e_aerr = 0; e_berr = 0;
        busy = 0;
      end
    end
  end

  // Cycle-by-cycle compare, plus strobe/ack counters used by the directed checks.
  int            push_cnt = 0, pop_cnt = 0, ack_cnt = 0;
  logic [DW-1:0] last_wd = '0;
  initial begin
    forever begin
      @(negedge clk);
      check("cycle_outputs",
            {2'b0, a_if.ack, a_if.err, a_if.rdata, b_if.ack, b_if.err, b_if.rdata,
             stk_push, stk_pop, stk_wdata},
            {2'b0, e_aack, e_aerr, e_ard, e_back, e_berr, e_brd, e_push, e_pop, e_wd});
      if (stk_push) begin push_cnt++; last_wd = stk_wdata; end
      if (stk_pop) pop_cnt++;
      if (a_if.ack || b_if.ack) ack_cnt++;
    end
  end

  // Issues one transaction from the current negedge and waits (bounded) for its ack.
  task automatic txn(input bit who_b, input bit op, input logic [DW-1:0] wd,
                     output bit err, output logic [DW-1:0] rd, output int lat);
    bit seen = 0;
    err = 0; rd = '0; lat = 0;
    if (who_b) begin b_if.req = 1; b_if.op = op; b_if.wdata = wd; end
    else       begin a_if.req = 1; a_if.op = op; a_if.wdata = wd; end
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (who_b ? b_if.ack : a_if.ack) begin
        seen = 1; lat = n;
        err  = who_b ? b_if.err : a_if.err;
        rd   = who_b ? b_if.rdata : a_if.rdata;
      end
    end
    a_if.req = 0; b_if.req = 0;
    check("ack_seen", {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            err;
    logic [DW-1:0] rd;
    int            lat, snap, snap2, errs, got, b_acks;
    logic [5:0]    order;

    a_if.req = 0; a_if.op = 0; a_if.wdata = '0;
    b_if.req = 0; b_if.op = 0; b_if.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {a_if.ack, a_if.err, b_if.ack, b_if.err, stk_push, stk_pop, 2'b0,
                            stk_wdata, a_if.rdata, b_if.rdata}, 32'h0);
    reset_n = 1;
    @(negedge clk);

    // Single push from A: one strobe carrying 0x11, ack two edges after sampling.
    snap = push_cnt;
    txn(0, 1, 8'h11, err, rd, lat);
    check("a_push_latency", lat, 2);
    check("a_push_err", {31'b0, err}, 0);
    check("a_push_strobes", push_cnt - snap, 1);
    check("a_push_wdata", {24'b0, last_wd}, 32'h11);

    // LIFO order across requesters.
    txn(1, 1, 8'h22, err, rd, lat);
    check("b_push_err", {31'b0, err}, 0);
    txn(0, 0, 8'h00, err, rd, lat);
    check("a_pop_rdata", {24'b0, rd}, 32'h22);
    txn(1, 0, 8'h00, err, rd, lat);
    check("b_pop_rdata", {24'b0, rd}, 32'h11);

    // Underflow from B clears its rdata and never strobes.
    snap = pop_cnt;
    txn(1, 0, 8'h00, err, rd, lat);
    check("b_underflow_err", {31'b0, err}, 1);
    check("b_underflow_rdata", {24'b0, rd}, 0);
    check("b_underflow_strobes", pop_cnt - snap, 0);

    // Fill to 16, then overflow.
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      txn(0, 1, 8'h30 + DW'(i), err, rd, lat);
      errs += int'(err);
    end
    check("fill_errs", errs, 0);
    check("full_after_fill", {31'b0, stk_full}, 1);
    snap = push_cnt;
    txn(0, 1, 8'hFF, err, rd, lat);
    check("overflow_err", {31'b0, err}, 1);
    check("overflow_strobes", push_cnt - snap, 0);
    check("full_after_overflow", {31'b0, stk_full}, 1);

    // Drain in reverse order.
    txn(0, 0, 8'h00, err, rd, lat);
    check("drain_first", {24'b0, rd}, 32'h3F);
    for (int i = 1; i < DEPTH; i++) txn(0, 0, 8'h00, err, rd, lat);
    check("drain_last", {24'b0, rd}, 32'h30);
    check("empty_after_drain", {31'b0, stk_empty}, 1);

    // B grant last, so A takes the first tie below.
    txn(1, 0, 8'h00, err, rd, lat);
    check("b_underflow2_err", {31'b0, err}, 1);

    // Both requesters held for six transactions.
    a_if.req = 1; a_if.op = 1; a_if.wdata = 8'hA0;
    b_if.req = 1; b_if.op = 1; b_if.wdata = 8'hB0;
    got = 0; b_acks = 0; order = '0;
    for (int n = 0; n < 60 && got < 6; n++) begin
      @(negedge clk);
      if (a_if.ack || b_if.ack) begin
        order = {order[4:0], b_if.ack};
        got++;
      end
      if (b_if.ack) b_acks++;
    end
    a_if.req = 0; b_if.req = 0;
    check("contend_acks", got, 6);
`ifdef STACK_ARB_FIXED_PRIO_EN
    check("contend_order", {26'b0, order}, 32'b000000);
    check("contend_b_acks", b_acks, 0);
`else
    check("contend_order", {26'b0, order}, 32'b010101);
    check("contend_b_acks", b_acks, 3);
`endif

    // Reset during the ISSUE cycle of a push.
    @(negedge clk);
    a_if.req = 1; a_if.op = 1; a_if.wdata = 8'h55;
    @(posedge clk);
    #2;
    check("issue_push_high", {31'b0, stk_push}, 1);
    snap2 = ack_cnt;
    reset_n = 0;
    #1;
    check("reset_push_drop", {31'b0, stk_push}, 0);
    a_if.req = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (4) @(negedge clk);
    check("reset_no_ack", ack_cnt - snap2, 0);
    check("reset_stack_empty", {31'b0, stk_empty}, 1);
    txn(1, 1, 8'h77, err, rd, lat);
    check("post_reset_latency", lat, 2);
    check("post_reset_err", {31'b0, err}, 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
